bandai2003_unlock_host: RTL and testbench

//  Console-side partner of the Bandai 2003 mapper unlock. On a start request it drives ADDR_ACK (0x5A)

---
 rtl/bandai2003_pkg.sv | 20 ++
 rtl/bandai2003_so_rx.sv | 66 ++++++
 rtl/bandai2003_unlock_host.sv | 169 ++++++++++++++++
 tb/tb_bandai2003_unlock_host.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bandai2003_pkg.sv
// Shared constants and types for the Bandai 2003 mapper unlock (host and mapper sides).
package bandai2003_pkg;

  localparam logic [7:0]  ADDR_ACK         = 8'h5A;
  localparam logic [7:0]  ADDR_NAK         = 8'hA5;
  localparam int unsigned FRAME_DATA_BITS  = 16;
  localparam logic [15:0] EXP_WORD_DEFAULT = 16'h28A0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_NAK,
    ST_WAIT_START,
    ST_DATA,
    ST_TRAIL,
    ST_PASSED,
    ST_FAILED
  } state_e;

endpackage

// File: rtl/bandai2003_so_rx.sv
// Mapper SO receiver: start-bit search with timeout, 16-bit LSB-first shift, trailer check.
module bandai2003_so_rx
  import bandai2003_pkg::*;
#(
  parameter logic [15:0] EXP_WORD = EXP_WORD_DEFAULT,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       clr_i,
  input  logic                       wait_i,
  input  logic                       data_i,
  input  logic                       trail_i,
  input  logic                       so_i,
  output logic                       frame_start_c_o,
  output logic                       last_bit_c_o,
  output logic                       bit_ok_c_o,
  output logic                       err_c_o,
  output logic [FRAME_DATA_BITS-1:0] rx_data_o
);

  localparam int unsigned TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned BCW = $clog2(FRAME_DATA_BITS);

  logic [TCW-1:0]             tmo_cnt_q, tmo_cnt_d;
  logic [BCW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [FRAME_DATA_BITS-1:0] rx_q, rx_d;
  logic                       tmo_hit;
  logic                       trail_ok;

  assign tmo_hit  = (tmo_cnt_q == TCW'(TIMEOUT - 1));
  assign trail_ok = ~so_i & (rx_q == EXP_WORD);

  assign frame_start_c_o = wait_i & ~so_i;
  assign last_bit_c_o    = data_i & (bit_cnt_q == BCW'(FRAME_DATA_BITS - 1));
  assign bit_ok_c_o      = trail_i & trail_ok;
  assign err_c_o         = (wait_i & so_i & tmo_hit) | (trail_i & ~trail_ok);
  assign rx_data_o       = rx_q;

  // Counters run only inside their phase and sit at zero otherwise; payload shifts in MSB-side.
  always_comb begin
    tmo_cnt_d = '0;
    bit_cnt_d = '0;
    rx_d      = rx_q;
    if (wait_i && so_i) tmo_cnt_d = tmo_cnt_q + TCW'(1);
    if (data_i) begin
      bit_cnt_d = bit_cnt_q + BCW'(1);
      rx_d      = {so_i, rx_q[FRAME_DATA_BITS-1:1]};
    end
    if (clr_i) rx_d = '0;
  end

  // Receiver state registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tmo_cnt_q <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
    end
  end

endmodule

// File: rtl/bandai2003_unlock_host.sv
// Console-side Bandai 2003 unlock: drives the ACK/NAK address pair, receives the mapper frame,
// sets sticky SYSTEM_CTRL1[7] on a matching payload. Optional auto-retry: BANDAI2003_RETRY_EN.
module bandai2003_unlock_host
  import bandai2003_pkg::*;
#(
  parameter logic [15:0] EXP_WORD  = EXP_WORD_DEFAULT,
  parameter int unsigned TIMEOUT   = 32,
  parameter logic [7:0]  IDLE_ADDR = 8'h00,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        start,
  output logic [7:0]  addr_o,
  input  logic        so_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] rx_data,
  output logic        ctrl1_b7
);

  if (TIMEOUT < 2 || IDLE_ADDR == ADDR_ACK || IDLE_ADDR == ADDR_NAK || MAX_RETRY > 255)
  begin : g_param_err
    $error("bandai2003_unlock_host: illegal parameter set");
  end

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       ctrl_q, ctrl_d;
  logic       rx_clr;
  logic       fail;
  logic       frame_start_c, last_bit_c, bit_ok_c, err_c;
  logic       in_wait, in_data, in_trail;

`ifdef BANDAI2003_RETRY_EN
  localparam int unsigned RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RCW-1:0] retry_q, retry_d;
`endif

  assign in_wait  = (state_q == ST_WAIT_START);
  assign in_data  = (state_q == ST_DATA);
  assign in_trail = (state_q == ST_TRAIL);

  bandai2003_so_rx #(
    .EXP_WORD (EXP_WORD),
    .TIMEOUT  (TIMEOUT)
  ) u_so_rx (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .clr_i           (rx_clr),
    .wait_i          (in_wait),
    .data_i          (in_data),
    .trail_i         (in_trail),
    .so_i            (so_i),
    .frame_start_c_o (frame_start_c),
    .last_bit_c_o    (last_bit_c),
    .bit_ok_c_o      (bit_ok_c),
    .err_c_o         (err_c),
    .rx_data_o       (rx_data)
  );

  // Sequencer next state, fail/retry resolution and registered output values.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    ctrl_d  = ctrl_q;
    rx_clr  = 1'b0;
    fail    = 1'b0;
`ifdef BANDAI2003_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE, ST_FAILED: begin
        if (start) begin
          state_d = ST_ACK;
          rx_clr  = 1'b1;
          pass_d  = 1'b0;
`ifdef BANDAI2003_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      ST_ACK:        state_d = ST_NAK;
      ST_NAK:        state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (frame_start_c) state_d = ST_DATA;
        else if (err_c)    fail    = 1'b1;
      end
      ST_DATA: begin
        if (last_bit_c) state_d = ST_TRAIL;
      end
      ST_TRAIL: begin
        if (bit_ok_c) begin
          state_d = ST_PASSED;
          done_d  = 1'b1;
          pass_d  = 1'b1;
          ctrl_d  = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end
      ST_PASSED: state_d = ST_PASSED;
      default:   state_d = ST_IDLE;
    endcase

    if (fail) begin
`ifdef BANDAI2003_RETRY_EN
      if (retry_q < RCW'(MAX_RETRY)) begin
        state_d = ST_ACK;
        retry_d = retry_q + RCW'(1);
        rx_clr  = 1'b1;
      end else begin
        state_d = ST_FAILED;
        done_d  = 1'b1;
        pass_d  = 1'b0;
      end
`else
      state_d = ST_FAILED;
      done_d  = 1'b1;
      pass_d  = 1'b0;
`endif
    end

    case (state_d)
      ST_ACK:  addr_d = ADDR_ACK;
      ST_NAK:  addr_d = ADDR_NAK;
      default: addr_d = IDLE_ADDR;
    endcase
    busy_d = (state_d == ST_ACK) || (state_d == ST_NAK) || (state_d == ST_WAIT_START) ||
             (state_d == ST_DATA) || (state_d == ST_TRAIL);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      addr_q  <= IDLE_ADDR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ctrl_q  <= 1'b0;
`ifdef BANDAI2003_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ctrl_q  <= ctrl_d;
`ifdef BANDAI2003_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign addr_o   = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign ctrl1_b7 = ctrl_q;

endmodule

// File: tb/tb_bandai2003_unlock_host.sv
// Bench for bandai2003_unlock_host: mapper model on SO, run-level reference model, scoreboard monitor.
module tb_bandai2003_unlock_host;
  import bandai2003_pkg::*;

  localparam logic [15:0] EXP  = 16'h28A0;
  localparam int          TMO  = 32;
  localparam logic [7:0]  IDLE = 8'h00;
`ifdef BANDAI2003_RETRY_EN
  localparam int          MAXR = 3;
`else
  localparam int          MAXR = 0;
`endif

  logic        CLK   = 1'b0;
  logic        RSTn  = 1'b1;
  logic        start = 1'b0;
  logic        so_i  = 1'b1;
  logic [7:0]  addr_o;
  logic        busy, done, pass, ctrl1_b7;
  logic [15:0] rx_data;

  always #5 CLK = ~CLK;

  bandai2003_unlock_host #(
    .EXP_WORD  (EXP),
    .TIMEOUT   (TMO),
    .IDLE_ADDR (IDLE),
    .MAX_RETRY (3)
  ) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .start    (start),
    .addr_o   (addr_o),
    .so_i     (so_i),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .rx_data  (rx_data),
    .ctrl1_b7 (ctrl1_b7)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  typedef struct { int cyc; logic [7:0] val; } addr_exp_t;
  typedef struct { int cyc; logic ok; logic [15:0] rx; logic ctrl; } done_exp_t;
  addr_exp_t addr_q[$];
  done_exp_t done_q[$];

  // mapper configuration: answers from unlock number map_from on (0 = never answers)
  int          map_from     = 0;
  logic [15:0] map_payload  = 16'h0;
  logic        map_trailer  = 1'b0;
  int          map_attempts = 0;

  // reference model state
  int m_attempts = 0;
  bit m_active   = 1'b0;
  bit m_passed   = 1'b0;
  bit m_ctrl     = 1'b0;
  int m_e0       = 0;
  int m_end      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mapper: after seeing 5A then A5 on the address bus it shifts start, payload LSB first, trailer.
  initial begin
    logic [7:0]  prev;
    logic [7:0]  cur;
    logic [17:0] frame;
    prev = IDLE;
    cur  = IDLE;
    forever begin
      @(negedge CLK);
      prev = cur;
      cur  = addr_o;
      if (prev == ADDR_ACK && cur == ADDR_NAK) begin
        map_attempts++;
        if (map_from != 0 && map_attempts >= map_from) begin
          frame = {map_trailer, map_payload, 1'b0};
          for (int i = 0; i < 18; i++) begin
            @(posedge CLK);
            #1 so_i = frame[i];
          end
          @(posedge CLK);
          #1 so_i = 1'b1;
          prev = IDLE;
          cur  = IDLE;
        end
      end
    end
  end

  // Reference model: start seen after edge k is taken at edge k+1 unless busy or already passed.
  // Each attempt is 20 edges when the mapper answers, 2+TIMEOUT edges when it stays silent.
  task automatic model_start(input int k);
    int          e;
    int          fin;
    int          n;
    bit          ans;
    bit          ok;
    logic [15:0] rx;
    addr_exp_t   a;
    done_exp_t   d;
    if (m_passed || (m_active && k < m_end)) return;
    e    = k + 1;
    m_e0 = e;
    n    = 0;
    fin  = e;
    ok   = 1'b0;
    rx   = '0;
    forever begin
      m_attempts++;
      a.cyc = e;     a.val = ADDR_ACK; addr_q.push_back(a);
      a.cyc = e + 1; a.val = ADDR_NAK; addr_q.push_back(a);
      ans = (map_from != 0) && (m_attempts >= map_from);
      if (ans) begin
        fin = e + 20;
        ok  = (map_payload == EXP) && !map_trailer;
        rx  = map_payload;
      end else begin
        fin = e + 2 + TMO;
        ok  = 1'b0;
        rx  = '0;
      end
      if (ok || n >= MAXR) break;
      n++;
      e = fin;
    end
    m_ctrl   = m_ctrl | ok;
    m_passed = ok;
    m_end    = fin;
    m_active = 1'b1;
    d.cyc = fin; d.ok = ok; d.rx = rx; d.ctrl = m_ctrl;
    done_q.push_back(d);
  endtask

  // Monitor: busy window every cycle; address and done events popped from the scoreboard.
  always @(negedge CLK) begin
    addr_exp_t a;
    done_exp_t d;
    if (RSTn && mon_en) begin
      check("busy", 32'(busy), 32'(m_active && cyc >= m_e0 && cyc < m_end));
      if (addr_o !== IDLE) begin
        if (addr_q.size() == 0) check("addr_unexpected", 32'(addr_o), 32'(IDLE));
        else begin
          a = addr_q.pop_front();
          check("addr_cycle", 32'(cyc), 32'(a.cyc));
          check("addr_val", 32'(addr_o), 32'(a.val));
        end
      end
      if (done !== 1'b0) begin
        if (done_q.size() == 0) check("done_unexpected", 32'(done), 32'h0);
        else begin
          d = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(d.cyc));
          check("pass", 32'(pass), 32'(d.ok));
          check("rx_data", 32'(rx_data), 32'(d.rx));
          check("ctrl1_b7", 32'(ctrl1_b7), 32'(d.ctrl));
        end
      end
    end
  end

  task automatic tick(input int n);
    int m;
    m = (n < 1) ? 1 : n;
    repeat (m) @(posedge CLK);
    #1;
  endtask

  task automatic set_map(input int from, input logic [15:0] payload, input logic trailer);
    map_from     = from;
    map_payload  = payload;
    map_trailer  = trailer;
    map_attempts = 0;
    m_attempts   = 0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    addr_q.delete();
    done_q.delete();
    m_active     = 1'b0;
    m_passed     = 1'b0;
    m_ctrl       = 1'b0;
    m_attempts   = 0;
    map_attempts = 0;
    #1;
    check("rst_addr", 32'(addr_o), 32'(IDLE));
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    check("rst_rx", 32'(rx_data), 32'h0);
    check("rst_ctrl", 32'(ctrl1_b7), 32'h0);
    @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  task automatic issue_start();
    start = 1'b1;
    model_start(cyc);
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    if (m_active && m_end >= cyc) tick(m_end - cyc + 2);
    else tick(2);
  endtask

  initial begin
    #1 RSTn = 1'b0;
    tick(2);
    do_reset();
    mon_en = 1'b1;

    // silent mapper: timeout, then a rerun from FAILED
    set_map(0, EXP, 1'b0);
    tick(5);
    issue_start();
    wait_done();
    issue_start();
    wait_done();

    // wrong payload, then wrong trailer
    set_map(1, 16'h28A1, 1'b0);
    issue_start();
    wait_done();
    set_map(1, EXP, 1'b1);
    issue_start();
    wait_done();

    // good unlock with starts while busy, then a start in PASSED
    set_map(1, EXP, 1'b0);
    issue_start();
    tick(1);
    issue_start();
    tick(3);
    issue_start();
    wait_done();
    issue_start();
    tick(30);

    // reset at the DATA bit-8 edge, then a fresh passing run
    do_reset();
    set_map(1, EXP, 1'b0);
    issue_start();
    tick(12);
    do_reset();
    tick(30);
    issue_start();
    wait_done();
    tick(5);

    // mapper answers only on the third unlock; mapper never answers
    do_reset();
    set_map(3, EXP, 1'b0);
    issue_start();
    wait_done();
    tick(5);
    do_reset();
    set_map(0, EXP, 1'b0);
    issue_start();
    wait_done();
    tick(5);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int j = 0; j < 4; j++) begin
        set_map($urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? EXP : 16'($urandom),
                ($urandom_range(0, 3) == 0));
        tick($urandom_range(1, 6));
        issue_start();
        if ($urandom_range(0, 1) == 1) begin
          tick($urandom_range(1, 15));
          issue_start();
        end
        wait_done();
        tick($urandom_range(1, 4));
      end
      tick(25);
    end

    tick(5);
    check("addr_q_empty", 32'(addr_q.size()), 32'h0);
    check("done_q_empty", 32'(done_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
